elastic_pipeline_register: RTL and testbench

Parametrised, handshake-driven pipeline stage register: generalises the fixed EX/MEM stage register into a reusable two-entry elastic (skid) buffer with valid/ready flow control, flush-to-NOP, and a stall-cycle counter. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It lets a downstream stall back-pressure upstream without a combinational path from `out_ready` to `in_ready`. Payload is an opaque bus; each stage packs its own fields (PC+4, control, ALU result, and so on) into it.

---
 rtl/elastic_pipeline_register.sv | 143 ++++++++++++++
 tb/tb_elastic_pipeline_register.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline_register.sv
// elastic_pipeline_register
//
// Reusable two-entry elastic (skid) pipeline stage with valid/ready flow control.
// A main register drives the output and a skid register absorbs one extra payload
// when downstream stalls. Because of the skid register, in_ready depends only on
// registered state, so there is no combinational path from out_ready back to in_ready.
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   reset        - asynchronous active-high reset; empties the stage at once
//   flush        - synchronous flush; empties the stage and drops any payload
//                  accepted in the same cycle
//   in_valid     - upstream payload valid
//   in_ready     - stage can accept (state != FULL)
//   in_payload   - upstream payload
//   out_valid    - stage holds a valid payload (state != EMPTY)
//   out_ready    - downstream accepts
//   out_payload  - head payload; NOP_PAYLOAD when empty
//   occupancy    - entries held: 0, 1 or 2
//   stall_cycles - saturating count of cycles with out_valid && !out_ready

module elastic_pipeline_register #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      NOP_PAYLOAD = '0,
    parameter int unsigned           CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_payload,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_payload,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic acc;
    logic dlv;

    // Handshake flags come only from registered state.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);

    assign acc = in_valid && in_ready;
    assign dlv = out_valid && out_ready;

    // main_q is held at NOP_PAYLOAD whenever the stage is empty, so the output
    // shows a bubble without needing a mux on out_valid.
    assign out_payload  = main_q;
    assign stall_cycles = stall_q;

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StEmpty: occupancy = 2'd0;
            StOne:   occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = StEmpty;
            main_d  = NOP_PAYLOAD;
            skid_d  = NOP_PAYLOAD;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (acc) begin
                        state_d = StOne;
                        main_d  = in_payload;
                    end
                end
                StOne: begin
                    if (acc && dlv) begin
                        main_d = in_payload;
                    end else if (acc) begin
                        state_d = StFull;
                        skid_d  = in_payload;
                    end else if (dlv) begin
                        state_d = StEmpty;
                        main_d  = NOP_PAYLOAD;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only a delivery can move us.
                    if (dlv) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = NOP_PAYLOAD;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = NOP_PAYLOAD;
                    skid_d  = NOP_PAYLOAD;
                end
            endcase
        end
    end

    // Stall counter ignores flush; only reset clears it.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            main_q  <= NOP_PAYLOAD;
            skid_q  <= NOP_PAYLOAD;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Testbench for elastic_pipeline_register: directed scenarios plus random traffic,
// checked against a queue-based FIFO model. Expected deliveries go into a scoreboard
// queue that a separate monitor drains whenever the DUT completes a handshake.

module tb_elastic_pipeline_register;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned CNT_W   = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [WIDTH-1:0] NOP = '0;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_payload;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_payload;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] model_q[$];  // stage contents, head first
    logic [WIDTH-1:0] exp_q[$];    // scoreboard of expected deliveries
    int               stall_m;

    elastic_pipeline_register #(
        .WIDTH       (WIDTH),
        .NOP_PAYLOAD (NOP),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_payload   (in_payload),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_payload  (out_payload),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, " occupancy"}, 64'(occupancy), 64'(sz));
        chk({tag, " in_ready"}, 64'(in_ready), 64'(sz < 2));
        chk({tag, " out_valid"}, 64'(out_valid), 64'(sz > 0));
        chk({tag, " stall_cycles"}, 64'(stall_cycles), 64'(stall_m));
        chk({tag, " out_payload"}, 64'(out_payload), (sz > 0) ? 64'(model_q[0]) : 64'(NOP));
    endtask

    // Called just after a rising edge; drives one cycle of inputs, advances the
    // model across the next edge and checks the visible state after it.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] p, input logic rdy,
                         input logic fl, input string tag);
        bit acc;
        bit dlv;
        in_valid   = v;
        in_payload = p;
        out_ready  = rdy;
        flush      = fl;
        acc = v && (model_q.size() < 2);
        dlv = (model_q.size() > 0) && rdy;
        if ((model_q.size() > 0) && !rdy && (stall_m < CNT_MAX)) stall_m++;
        if (dlv) exp_q.push_back(model_q[0]);
        if (fl) begin
            model_q.delete();
        end else begin
            if (dlv) void'(model_q.pop_front());
            if (acc) model_q.push_back(p);
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        stall_m = 0;
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear before
    // the next rising edge.
    task automatic async_reset(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_state(tag);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: mid-cycle, a valid && ready pair means a delivery at the next edge.
    initial begin
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected delivery", 64'(out_payload), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("delivered payload", 64'(out_payload), 64'(e));
                end
            end
            if (!out_valid) chk("bubble payload", 64'(out_payload), 64'(NOP));
        end
    end

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_payload = '0;
        out_ready  = 1'b0;
        model_reset();

        #12;
        check_state("mid-reset");
        #20;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_state("post-reset");

        // Streaming at full rate.
        cycle(1'b1, 32'h0000_0008, 1'b1, 1'b0, "stream0");
        cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, "stream1");
        cycle(1'b1, 32'h2000_0030, 1'b1, 1'b0, "stream2");
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "stream-drain");

        // Skid absorption and drain.
        cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0, "skid-load");
        cycle(1'b1, 32'h2222_2222, 1'b0, 1'b0, "skid-full");
        cycle(1'b1, 32'h3333_3333, 1'b0, 1'b0, "skid-blocked");
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "skid-drain0");
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "skid-drain1");

        // Flush while full with a competing input.
        cycle(1'b1, 32'h0000_00A1, 1'b0, 1'b0, "flush-fill0");
        cycle(1'b1, 32'h0000_00A2, 1'b0, 1'b0, "flush-fill1");
        cycle(1'b1, 32'h0000_000B, 1'b0, 1'b1, "flush");
        cycle(1'b0, 32'h0, 1'b1, 1'b0, "post-flush");
        // Flush from ONE with simultaneous accept and delivery.
        cycle(1'b1, 32'h0000_00C1, 1'b1, 1'b0, "flush2-fill");
        cycle(1'b1, 32'h0000_00C2, 1'b1, 1'b1, "flush2");

        // Stall counter saturation and persistence.
        async_reset("stall-reset");
        cycle(1'b1, 32'h0000_5A5A, 1'b0, 1'b0, "sat-load");
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, "sat");
        cycle(1'b0, 32'h0, 1'b0, 1'b1, "sat-flush");
        cycle(1'b0, 32'h0, 1'b0, 1'b0, "sat-idle");

        // Asynchronous reset while FULL.
        cycle(1'b1, 32'h0000_0E01, 1'b0, 1'b0, "ar-fill0");
        cycle(1'b1, 32'h0000_0E02, 1'b0, 1'b0, "ar-fill1");
        async_reset("async-reset");
        @(posedge clk);
        #1;
        check_state("async-release");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 19) == 0), "random");
            if ($urandom_range(0, 149) == 0) async_reset("random-reset");
        end

        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, "final-drain");
        @(negedge clk);
        chk("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
